// File: rtl/sprite_fetch_scheduler_pkg.sv
// Shared widths, FSM state type and tile ROM content pattern for the sprite fetch path.
package sprite_fetch_scheduler_pkg;

  localparam int SPRITE_TILEROM_ADDRBIT = 10;
  localparam int SPRITE_TILEDATA_BIT    = 16;
  localparam int SPRITE_NUM             = 64;
  localparam int SPRITE_IDX_BIT         = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } fetch_state_t;

  // Tile ROM word j holds j*0x11, truncated to the data width by the caller.
  function automatic logic [31:0] tile_pattern(input logic [31:0] addr);
    return addr * 32'h11;
  endfunction

endpackage

// File: rtl/sprite_fetch_scheduler_rom.sv
// Single-port registered sprite tile ROM; read data appears one cycle after en.
module sprite_tile_rom_sp
  import sprite_fetch_scheduler_pkg::*;
#(
  parameter int ADDR_W = SPRITE_TILEROM_ADDRBIT,
  parameter int DATA_W = SPRITE_TILEDATA_BIT
) (
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Content is generated from the tile pattern rather than loaded from an image file.
  always_ff @(posedge clk) begin
    if (en) data <= DATA_W'(tile_pattern(32'(addr)));
  end

endmodule

// File: rtl/sprite_fetch_scheduler.sv
// Walks all sprite slots once per line, sharing one registered tile ROM and
// writing every slot's tile row (or zero when inactive) into the line buffer.
module sprite_fetch_scheduler
  import sprite_fetch_scheduler_pkg::*;
#(
  parameter int NUM_SPRITES = SPRITE_NUM,
  parameter int ADDR_W      = SPRITE_TILEROM_ADDRBIT,
  parameter int DATA_W      = SPRITE_TILEDATA_BIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          line_start,
  input  logic [NUM_SPRITES-1:0]        req_valid,
  input  logic [NUM_SPRITES*ADDR_W-1:0] req_addr,
  output logic                          rom_en,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [DATA_W-1:0]             rom_data,
  output logic                          wr_en,
  output logic [SPRITE_IDX_BIT-1:0]     wr_idx,
  output logic [DATA_W-1:0]             wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int                IDX_W    = SPRITE_IDX_BIT;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_SPRITES - 1);

  fetch_state_t           state, state_n;
  logic [IDX_W-1:0]       idx, idx_n;
  logic [NUM_SPRITES-1:0] mask, mask_n;

  logic                   wvalid;
  logic                   wmask;
  logic [IDX_W-1:0]       widx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      mask    <= '0;
      wvalid  <= 1'b0;
      wmask   <= 1'b0;
      widx    <= '0;
      overrun <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      mask   <= mask_n;
      // Write stage trails the issue stage by exactly the ROM read latency.
      wvalid <= (state == ST_SCAN);
      wmask  <= mask[idx];
      widx   <= idx;
      if (line_start && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    mask_n   = mask;
    rom_en   = 1'b0;
    rom_addr = '0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (line_start) begin
          mask_n  = req_valid;
          idx_n   = '0;
          state_n = ST_SCAN;
        end
      end
      ST_SCAN: begin
        busy  = 1'b1;
        idx_n = idx + 1'b1;
        if (mask[idx]) begin
          rom_en   = 1'b1;
          rom_addr = req_addr[int'(idx)*ADDR_W +: ADDR_W];
        end
        if (idx == LAST_IDX) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign wr_en   = wvalid;
  assign wr_idx  = widx;
  assign wr_data = (wvalid && wmask) ? rom_data : '0;

endmodule
